// File: rtl/tpu_buffer_sequencer.sv
// Unified-buffer sequencer: turns control strobes into SRAM matrix reads/writes and skewed array feeds.
// Latency: reads N*N+1 cycles (+1 weight commit), feed 2N-1, write N*N; no backpressure, strobes while busy are dropped and flag overrun.
module tpu_buffer_sequencer #(
  parameter int N      = 2,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 13
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_weight,
  input  logic                      load_input,
  input  logic                      valid,
  input  logic                      store,
  input  logic [ADDR_W-1:0]         base_address,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_rd_en,
  input  logic [ACC_W-1:0]          mem_rdata,
  output logic                      mem_wr_en,
  output logic [ACC_W-1:0]          mem_wdata,
  output logic [N*N*DATA_W-1:0]     weight_out,
  output logic                      weight_load,
  output logic [N*DATA_W-1:0]       array_in,
  output logic                      array_in_valid,
  input  logic [N*N*ACC_W-1:0]      acc_in,
  output logic                      busy,
  output logic                      done,
  output logic                      overrun
);

  localparam int NN    = N * N;
  localparam int CNT_W = $clog2(NN + 2 * N + 2);

  typedef enum logic [2:0] {IDLE, RD_W, RD_I, FEED, WR} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cap_idx;
  logic [NN*DATA_W-1:0]   wbuf;
  logic [NN*DATA_W-1:0]   ibuf;
  logic [3:0]             strobe;
  logic [3:0]             strobe_q;
  logic [3:0]             rise;
  logic                   unused_rdata;

  // Bit order gives the acceptance priority: store > load_weight > load_input > valid.
  assign strobe       = {store, load_weight, load_input, valid};
  assign rise         = strobe & ~strobe_q;
  assign cap_idx      = cnt - CNT_W'(1);
  assign busy         = (state != IDLE);
  assign mem_wdata    = mem_wr_en ? acc_in[int'(cnt)*ACC_W +: ACC_W] : '0;
  assign unused_rdata = ^mem_rdata[ACC_W-1:DATA_W];

  function automatic logic [N*DATA_W-1:0] feed_rows(input logic [NN*DATA_W-1:0] mat, input int t);
    logic [N*DATA_W-1:0] rows;
    rows = '0;
    for (int r = 0; r < N; r++) begin
      if (t - r >= 0 && t - r < N)
        rows[r*DATA_W +: DATA_W] = mat[(r*N + t - r)*DATA_W +: DATA_W];
    end
    return rows;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      wbuf           <= '0;
      ibuf           <= '0;
      strobe_q       <= '0;
      mem_addr       <= '0;
      mem_rd_en      <= 1'b0;
      mem_wr_en      <= 1'b0;
      weight_out     <= '0;
      weight_load    <= 1'b0;
      array_in       <= '0;
      array_in_valid <= 1'b0;
      done           <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      strobe_q    <= strobe;
      done        <= 1'b0;
      weight_load <= 1'b0;
      if (state != IDLE && |rise)
        overrun <= 1'b1;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (rise[3]) begin
            state     <= WR;
            mem_addr  <= base_address;
            mem_wr_en <= 1'b1;
            if (|rise[2:0]) overrun <= 1'b1;
          end else if (rise[2]) begin
            state     <= RD_W;
            mem_addr  <= base_address;
            mem_rd_en <= 1'b1;
            if (|rise[1:0]) overrun <= 1'b1;
          end else if (rise[1]) begin
            state     <= RD_I;
            mem_addr  <= base_address;
            mem_rd_en <= 1'b1;
            if (rise[0]) overrun <= 1'b1;
          end else if (rise[0]) begin
            state          <= FEED;
            array_in       <= feed_rows(ibuf, 0);
            array_in_valid <= 1'b1;
          end
        end

        RD_W, RD_I: begin
          cnt <= cnt + 1'b1;
          if (cnt < CNT_W'(NN - 1)) begin
            mem_addr <= mem_addr + 1'b1;
          end else begin
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
          end
          // Read data lags its address by one cycle, so cycle k captures element k-1.
          if (cnt != '0 && cnt <= CNT_W'(NN)) begin
            if (state == RD_W) wbuf[cap_idx*DATA_W +: DATA_W] <= mem_rdata[DATA_W-1:0];
            else               ibuf[cap_idx*DATA_W +: DATA_W] <= mem_rdata[DATA_W-1:0];
          end
          if (state == RD_I && cnt == CNT_W'(NN)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
          if (state == RD_W && cnt == CNT_W'(NN + 1)) begin
            state       <= IDLE;
            done        <= 1'b1;
            weight_out  <= wbuf;
            weight_load <= 1'b1;
          end
        end

        FEED: begin
          if (cnt == CNT_W'(2 * N - 2)) begin
            state          <= IDLE;
            done           <= 1'b1;
            array_in       <= '0;
            array_in_valid <= 1'b0;
          end else begin
            cnt      <= cnt + 1'b1;
            array_in <= feed_rows(ibuf, int'(cnt) + 1);
          end
        end

        WR: begin
          if (cnt == CNT_W'(NN - 1)) begin
            state     <= IDLE;
            done      <= 1'b1;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
          end else begin
            cnt      <= cnt + 1'b1;
            mem_addr <= mem_addr + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_buffer_sequencer.sv
// Directed bench for tpu_buffer_sequencer: SRAM model plus per-scenario tasks with hand-computed expectations.
module tb_tpu_buffer_sequencer;
  localparam int N      = 2;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int ADDR_W = 13;

  logic                  clk;
  logic                  reset;
  logic                  load_weight, load_input, valid, store;
  logic [ADDR_W-1:0]     base_address;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_rd_en, mem_wr_en;
  logic [ACC_W-1:0]      mem_rdata, mem_wdata;
  logic [N*N*DATA_W-1:0] weight_out;
  logic                  weight_load;
  logic [N*DATA_W-1:0]   array_in;
  logic                  array_in_valid;
  logic [N*N*ACC_W-1:0]  acc_in;
  logic                  busy, done, overrun;

  logic [ACC_W-1:0] sram [0:(1<<ADDR_W)-1];
  int errors = 0;
  int checks = 0;

  tpu_buffer_sequencer #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .load_weight(load_weight), .load_input(load_input), .valid(valid), .store(store),
    .base_address(base_address),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .weight_out(weight_out), .weight_load(weight_load),
    .array_in(array_in), .array_in_valid(array_in_valid),
    .acc_in(acc_in), .busy(busy), .done(done), .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read SRAM: data appears the cycle after the read enable.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= sram[mem_addr];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; load_weight = 0; load_input = 0; valid = 0; store = 0;
    base_address = '0; acc_in = '0;
    tick; tick;
    checks++;
    if ({busy, done, overrun, weight_load, mem_rd_en, mem_wr_en, array_in_valid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000000",
               {busy, done, overrun, weight_load, mem_rd_en, mem_wr_en, array_in_valid});
    end
    checks++;
    if (weight_out !== '0 || array_in !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_data: weight_out=%h array_in=%h addr=%h wdata=%h want all 0",
               weight_out, array_in, mem_addr, mem_wdata);
    end
    reset = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b rd_en=%b want 0 0", busy, mem_rd_en);
    end
  endtask

  // Issues a weight load from base and checks the four read addresses and the commit timing.
  task automatic run_load_weight(input logic [ADDR_W-1:0] base, input logic [N*N*DATA_W-1:0] exp_w,
                                 input string tag);
    logic [ADDR_W-1:0] exp_addr;
    load_weight = 1'b1; base_address = base;
    tick;
    load_weight = 1'b0;
    for (int k = 0; k < N*N; k++) begin
      exp_addr = ADDR_W'(int'(base) + k);
      checks++;
      if (mem_rd_en !== 1'b1 || mem_wr_en !== 1'b0 || mem_addr !== exp_addr || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_rd k=%0d: rd=%b wr=%b addr=%h busy=%b want rd=1 wr=0 addr=%h busy=1",
                 tag, k, mem_rd_en, mem_wr_en, mem_addr, busy, exp_addr);
      end
      tick;
    end
    checks++;
    if (mem_rd_en !== 1'b0 || weight_load !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_tail: rd=%b wl=%b done=%b want 0 0 0", tag, mem_rd_en, weight_load, done);
    end
    tick;
    checks++;
    if (weight_load !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_early: wl=%b done=%b busy=%b want 0 0 1", tag, weight_load, done, busy);
    end
    tick;
    checks++;
    if (weight_load !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || weight_out !== exp_w) begin
      errors++;
      $display("FAIL %s_commit: wl=%b done=%b busy=%b weight_out=%h want 1 1 0 %h",
               tag, weight_load, done, busy, weight_out, exp_w);
    end
    tick;
    checks++;
    if (weight_load !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: wl=%b done=%b want 0 0", tag, weight_load, done);
    end
  endtask

  task automatic test_load_weight;
    sram[13'h010] = 16'hAB01; sram[13'h011] = 16'h0002;
    sram[13'h012] = 16'h0003; sram[13'h013] = 16'hFF04;
    run_load_weight(13'h010, 32'h04030201, "lw");
  endtask

  task automatic test_load_input_feed;
    logic [N*DATA_W-1:0] exp_rows [0:2];
    exp_rows[0] = 16'h0005; exp_rows[1] = 16'h0706; exp_rows[2] = 16'h0800;
    sram[13'h020] = 16'd5; sram[13'h021] = 16'd6; sram[13'h022] = 16'd7; sram[13'h023] = 16'd8;
    load_input = 1'b1; base_address = 13'h020;
    tick;
    load_input = 1'b0;
    tick; tick; tick; tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL li_early: done=%b busy=%b want 0 1", done, busy);
    end
    tick;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || weight_load !== 1'b0 || weight_out !== 32'h04030201) begin
      errors++;
      $display("FAIL li_done: done=%b busy=%b wl=%b weight_out=%h want 1 0 0 04030201",
               done, busy, weight_load, weight_out);
    end
    valid = 1'b1;
    tick;
    for (int t = 0; t < 2*N-1; t++) begin
      checks++;
      if (array_in_valid !== 1'b1 || array_in !== exp_rows[t] || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL feed t=%0d: vld=%b array_in=%h rd=%b wr=%b want 1 %h 0 0",
                 t, array_in_valid, array_in, mem_rd_en, mem_wr_en, exp_rows[t]);
      end
      tick;
    end
    checks++;
    if (array_in_valid !== 1'b0 || done !== 1'b1 || array_in !== '0) begin
      errors++;
      $display("FAIL feed_end: vld=%b done=%b array_in=%h want 0 1 0", array_in_valid, done, array_in);
    end
    tick; tick;
    valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || array_in_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL feed_level: busy=%b vld=%b overrun=%b want 0 0 0", busy, array_in_valid, overrun);
    end
    tick;
  endtask

  task automatic test_store;
    logic [ADDR_W-1:0] exp_addr;
    logic [ACC_W-1:0]  exp_data;
    acc_in = {16'd40, 16'd30, 16'd20, 16'd10};
    store = 1'b1; base_address = 13'h040;
    tick;
    store = 1'b0;
    for (int k = 0; k < N*N; k++) begin
      exp_addr = ADDR_W'(13'h040 + k);
      exp_data = ACC_W'(10 * (k + 1));
      checks++;
      if (mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0 || mem_addr !== exp_addr || mem_wdata !== exp_data) begin
        errors++;
        $display("FAIL wr k=%0d: wr=%b rd=%b addr=%h data=%0d want 1 0 %h %0d",
                 k, mem_wr_en, mem_rd_en, mem_addr, mem_wdata, exp_addr, exp_data);
      end
      tick;
    end
    checks++;
    if (mem_wr_en !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_done: wr=%b done=%b busy=%b want 0 1 0", mem_wr_en, done, busy);
    end
    tick;
  endtask

  task automatic test_wrap;
    sram[13'h1FFE] = 16'd9; sram[13'h1FFF] = 16'd10; sram[13'h0000] = 16'd11; sram[13'h0001] = 16'd12;
    run_load_weight(13'h1FFE, 32'h0C0B0A09, "wrap");
  endtask

  task automatic test_busy_overrun;
    load_weight = 1'b1; base_address = 13'h010;
    tick;
    load_weight = 1'b0;
    tick;
    load_input = 1'b1;
    tick;
    load_input = 1'b0;
    checks++;
    if (overrun !== 1'b1 || mem_rd_en !== 1'b1 || mem_addr !== 13'h012) begin
      errors++;
      $display("FAIL ovr_busy: overrun=%b rd=%b addr=%h want 1 1 012", overrun, mem_rd_en, mem_addr);
    end
    tick; tick; tick; tick;
    checks++;
    if (weight_load !== 1'b1 || done !== 1'b1 || weight_out !== 32'h04030201) begin
      errors++;
      $display("FAIL ovr_complete: wl=%b done=%b weight_out=%h want 1 1 04030201", weight_load, done, weight_out);
    end
    tick;
    checks++;
    if (busy !== 1'b0 || mem_rd_en !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_dropped: busy=%b rd=%b overrun=%b want 0 0 1", busy, mem_rd_en, overrun);
    end
  endtask

  task automatic test_reset_mid;
    int accesses;
    load_weight = 1'b1; base_address = 13'h010;
    tick;
    load_weight = 1'b0;
    tick; tick;
    reset = 1'b1;
    #2;
    checks++;
    if ({busy, done, overrun, weight_load, mem_rd_en, mem_wr_en, array_in_valid} !== 7'b0 ||
        weight_out !== '0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL rst_mid: flags=%b weight_out=%h addr=%h want 0000000 0 0",
               {busy, done, overrun, weight_load, mem_rd_en, mem_wr_en, array_in_valid}, weight_out, mem_addr);
    end
    tick;
    reset = 1'b0;
    accesses = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (mem_rd_en || mem_wr_en || busy) accesses++;
    end
    checks++;
    if (accesses !== 0) begin
      errors++;
      $display("FAIL rst_quiet: active cycles=%0d want 0", accesses);
    end
    valid = 1'b1;
    tick;
    valid = 1'b0;
    for (int t = 0; t < 2*N-1; t++) begin
      checks++;
      if (array_in_valid !== 1'b1 || array_in !== '0) begin
        errors++;
        $display("FAIL rst_ibuf t=%0d: vld=%b array_in=%h want 1 0", t, array_in_valid, array_in);
      end
      tick;
    end
    tick;
  endtask

  task automatic test_simultaneous;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL sim_pre: overrun=%b want 0", overrun);
    end
    acc_in = {16'd4, 16'd3, 16'd2, 16'd1};
    load_weight = 1'b1; store = 1'b1; base_address = 13'h050;
    tick;
    load_weight = 1'b0; store = 1'b0;
    checks++;
    if (mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0 || mem_addr !== 13'h050 || mem_wdata !== 16'd1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL sim_wr: wr=%b rd=%b addr=%h data=%0d overrun=%b want 1 0 050 1 1",
               mem_wr_en, mem_rd_en, mem_addr, mem_wdata, overrun);
    end
    tick; tick; tick; tick;
    checks++;
    if (done !== 1'b1 || weight_load !== 1'b0 || weight_out !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL sim_done: done=%b wl=%b weight_out=%h busy=%b want 1 0 0 0", done, weight_load, weight_out, busy);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) sram[i] = '0;
    test_reset;
    test_load_weight;
    test_load_input_feed;
    test_store;
    test_wrap;
    test_busy_overrun;
    test_reset_mid;
    test_simultaneous;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
